// File: rtl/cpu_selftest_ctrl.sv
// Self-test sequencer: loads a buffered program into the core's imem, runs the core
// for a bounded time, then checks register-file contents against an expected table.
module cpu_selftest_ctrl #(
    parameter int XLEN       = 32,
    parameter int PROG_DEPTH = 16,
    parameter int CHK_DEPTH  = 8,
    parameter int RUN_CYCLES = 40,
    parameter int PAW        = $clog2(PROG_DEPTH),
    parameter int CAW        = $clog2(CHK_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cfg_prog_we,
    input  logic [PAW-1:0]  cfg_prog_addr,
    input  logic [31:0]     cfg_prog_data,
    input  logic [PAW:0]    cfg_prog_len,
    input  logic            cfg_chk_we,
    input  logic [CAW-1:0]  cfg_chk_addr,
    input  logic [4:0]      cfg_chk_reg,
    input  logic [XLEN-1:0] cfg_chk_val,
    input  logic [CAW:0]    cfg_chk_cnt,
    input  logic            core_halt,
    output logic            imem_we,
    output logic [PAW-1:0]  imem_addr,
    output logic [31:0]     imem_wdata,
    output logic            core_rst_n,
    output logic [4:0]      dbg_raddr,
    input  logic [XLEN-1:0] dbg_rdata,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CAW:0]    mismatch_cnt,
    output logic [CAW-1:0]  fail_idx,
    output logic [XLEN-1:0] fail_val,
    output logic [15:0]     run_cycles
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

    localparam logic [PAW:0] LEN_MAX = (PAW+1)'(PROG_DEPTH);
    localparam logic [CAW:0] CNT_MAX = (CAW+1)'(CHK_DEPTH);

    state_t state, state_nx;

    logic [31:0]     prog_buf [PROG_DEPTH];
    logic [4:0]      chk_reg  [CHK_DEPTH];
    logic [XLEN-1:0] chk_val  [CHK_DEPTH];

    logic [PAW:0] prog_len, ld_idx, ld_nxt, len_clamp;
    logic [CAW:0] chk_cnt, ck_idx, ck_nxt, cnt_clamp;
    logic [31:0]  run_ctr, run_nxt;
    logic         start_ok, load_last, run_exit, chk_last, ck_miss;

    // Configuration storage: writable only while idle/done, never reset.
    always_ff @(posedge clk) begin
        if (cfg_prog_we && !busy)
            prog_buf[cfg_prog_addr] <= cfg_prog_data;
        if (cfg_chk_we && !busy) begin
            chk_reg[cfg_chk_addr] <= cfg_chk_reg;
            chk_val[cfg_chk_addr] <= cfg_chk_val;
        end
    end

    always_comb begin
        start_ok  = start && (state == S_IDLE || state == S_DONE);
        len_clamp = (cfg_prog_len > LEN_MAX) ? LEN_MAX : cfg_prog_len;
        cnt_clamp = (cfg_chk_cnt > CNT_MAX) ? CNT_MAX : cfg_chk_cnt;
        ld_nxt    = ld_idx + 1'b1;
        load_last = (ld_nxt >= prog_len);
        run_nxt   = run_ctr + 1'b1;
        run_exit  = core_halt || (run_nxt >= 32'(RUN_CYCLES));
        ck_nxt    = ck_idx + 1'b1;
        chk_last  = (ck_nxt >= chk_cnt);
        ck_miss   = (state == S_CHECK) && (ck_idx < chk_cnt) &&
                    (dbg_rdata != chk_val[ck_idx[CAW-1:0]]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok)  state_nx = S_LOAD;
            S_LOAD:         if (load_last) state_nx = S_RUN;
            S_RUN:          if (run_exit)  state_nx = S_CHECK;
            S_CHECK:        if (chk_last)  state_nx = S_DONE;
            default:                       state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_LOAD) || (state == S_RUN) || (state == S_CHECK);
        done = (state == S_DONE);
        pass = done && (mismatch_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst_n   <= 1'b0;
            dbg_raddr    <= '0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
            fail_val     <= '0;
            run_cycles   <= '0;
            prog_len     <= '0;
            chk_cnt      <= '0;
            ld_idx       <= '0;
            ck_idx       <= '0;
            run_ctr      <= '0;
        end else begin
            // The core only leaves reset for the cycles spent in RUN.
            core_rst_n <= (state_nx == S_RUN);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        prog_len     <= len_clamp;
                        chk_cnt      <= cnt_clamp;
                        ld_idx       <= '0;
                        run_ctr      <= '0;
                        run_cycles   <= '0;
                        mismatch_cnt <= '0;
                        fail_idx     <= '0;
                        fail_val     <= '0;
                        imem_we      <= (len_clamp != '0);
                        imem_addr    <= '0;
                        imem_wdata   <= prog_buf[0];
                    end
                end
                S_LOAD: begin
                    if (!load_last) begin
                        ld_idx     <= ld_nxt;
                        imem_we    <= 1'b1;
                        imem_addr  <= ld_nxt[PAW-1:0];
                        imem_wdata <= prog_buf[ld_nxt[PAW-1:0]];
                    end else begin
                        imem_we    <= 1'b0;
                    end
                end
                S_RUN: begin
                    run_ctr <= run_nxt;
                    if (run_cycles != 16'hFFFF)
                        run_cycles <= run_cycles + 1'b1;
                    if (run_exit) begin
                        ck_idx    <= '0;
                        dbg_raddr <= chk_reg[0];
                    end
                end
                S_CHECK: begin
                    if (ck_miss) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                        if (mismatch_cnt == '0) begin
                            fail_idx <= ck_idx[CAW-1:0];
                            fail_val <= dbg_rdata;
                        end
                    end
                    if (!chk_last) begin
                        ck_idx    <= ck_nxt;
                        dbg_raddr <= chk_reg[ck_nxt[CAW-1:0]];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_selftest_ctrl.sv
// Directed bench for cpu_selftest_ctrl: scenario table plus hand sequences for
// busy-time pokes, restart-from-DONE and asynchronous reset in the middle of LOAD.
module tb_cpu_selftest_ctrl;

    localparam int XLEN = 32;
    localparam int PAW  = 4;
    localparam int CAW  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            cfg_prog_we;
    logic [PAW-1:0]  cfg_prog_addr;
    logic [31:0]     cfg_prog_data;
    logic [PAW:0]    cfg_prog_len;
    logic            cfg_chk_we;
    logic [CAW-1:0]  cfg_chk_addr;
    logic [4:0]      cfg_chk_reg;
    logic [XLEN-1:0] cfg_chk_val;
    logic [CAW:0]    cfg_chk_cnt;
    logic            core_halt;
    logic            imem_we;
    logic [PAW-1:0]  imem_addr;
    logic [31:0]     imem_wdata;
    logic            core_rst_n;
    logic [4:0]      dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
    logic            busy, done, pass;
    logic [CAW:0]    mismatch_cnt;
    logic [CAW-1:0]  fail_idx;
    logic [XLEN-1:0] fail_val;
    logic [15:0]     run_cycles;

    cpu_selftest_ctrl #(.XLEN(XLEN), .PROG_DEPTH(16), .CHK_DEPTH(8), .RUN_CYCLES(40)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_prog_we(cfg_prog_we), .cfg_prog_addr(cfg_prog_addr),
        .cfg_prog_data(cfg_prog_data), .cfg_prog_len(cfg_prog_len),
        .cfg_chk_we(cfg_chk_we), .cfg_chk_addr(cfg_chk_addr), .cfg_chk_reg(cfg_chk_reg),
        .cfg_chk_val(cfg_chk_val), .cfg_chk_cnt(cfg_chk_cnt), .core_halt(core_halt),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .fail_idx(fail_idx), .fail_val(fail_val), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Register file as left by the test program: x1=10, x2=20, x3=30.
    logic [31:0] rf [32];
    assign dbg_rdata = rf[dbg_raddr];

    logic [31:0] bufm [16];
    logic [31:0] cap  [16];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [PAW:0] len;
        logic [CAW:0] cnt;
        logic [31:0]  e2, e3, e0;
        int           halt_at;
        logic         pass;
        int           mis, fidx;
        logic [31:0]  fval;
        int           run, we;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_tables(input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e0);
        logic [4:0]  r [8];
        logic [31:0] v [8];
        r = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        v = '{32'd10, e2, e3, e0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_chk_we   = 1'b1;
            cfg_chk_addr = CAW'(i);
            cfg_chk_reg  = r[i];
            cfg_chk_val  = v[i];
        end
        @(negedge clk);
        cfg_chk_we = 1'b0;
    endtask

    task automatic kick(input logic [PAW:0] len, input logic [CAW:0] cnt);
        @(negedge clk);
        cfg_prog_len = len;
        cfg_chk_cnt  = cnt;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_mis_clr", mismatch_cnt, 0);
        chk("start_fidx_clr", fail_idx, 0);
        chk("start_fval_clr", fail_val, 0);
        chk("start_run_clr", run_cycles, 0);
    endtask

    // Observes one LOAD/RUN/CHECK pass; optionally pulses halt or pokes start/cfg during RUN.
    task automatic wait_done(input int halt_at, input int poke_at,
                             output int we_cnt, output int rc, output int addr_err);
        int c;
        we_cnt = 0; rc = 0; addr_err = 0;
        for (int i = 0; i < 16; i++) cap[i] = 32'h0;
        c = 0;
        while (!done && c < 400) begin
            core_halt   = 1'b0;
            start       = 1'b0;
            cfg_prog_we = 1'b0;
            if (imem_we) begin
                if (int'(imem_addr) != we_cnt) addr_err++;
                cap[imem_addr] = imem_wdata;
                we_cnt++;
            end
            if (core_rst_n) begin
                rc++;
                if (rc == halt_at) core_halt = 1'b1;
                if (rc == poke_at) begin
                    start         = 1'b1;
                    cfg_prog_we   = 1'b1;
                    cfg_prog_addr = '0;
                    cfg_prog_data = 32'hDEADBEEF;
                end
            end
            @(negedge clk);
            c++;
        end
        core_halt = 1'b0; start = 1'b0; cfg_prog_we = 1'b0;
        chk("timeout_done", done, 1);
    endtask

    int we_cnt, rc, addr_err, data_err;

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_prog_we = 1'b0; cfg_prog_addr = '0;
        cfg_prog_data = '0; cfg_prog_len = '0; cfg_chk_we = 1'b0; cfg_chk_addr = '0;
        cfg_chk_reg = '0; cfg_chk_val = '0; cfg_chk_cnt = '0; core_halt = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd10; rf[2] = 32'd20; rf[3] = 32'd30;
        bufm[0] = 32'h00a00093; bufm[1] = 32'h01400113; bufm[2] = 32'h002081b3;
        for (int i = 3; i < 16; i++) bufm[i] = 32'hC0DE0000 | i;

        //            len    cnt   e2      e3      e0     halt pass mis fidx fval    run we
        vt[0] = '{5'd3,  4'd3, 32'd20, 32'd30, 32'd0, 0, 1'b1, 0, 0, 32'd0,  40, 3};
        vt[1] = '{5'd3,  4'd3, 32'd21, 32'd31, 32'd0, 0, 1'b0, 2, 1, 32'd20, 40, 3};
        vt[2] = '{5'd3,  4'd3, 32'd20, 32'd30, 32'd0, 5, 1'b1, 0, 0, 32'd0,  5,  3};
        vt[3] = '{5'd0,  4'd0, 32'd99, 32'd99, 32'd0, 0, 1'b1, 0, 0, 32'd0,  40, 0};
        vt[4] = '{5'd31, 4'd15,32'd20, 32'd30, 32'd0, 0, 1'b1, 0, 0, 32'd0,  40, 16};
        vt[5] = '{5'd3,  4'd3, 32'd21, 32'd30, 32'd0, 1, 1'b0, 1, 1, 32'd20, 1,  3};
        vt[6] = '{5'd3,  4'd4, 32'd20, 32'd30, 32'd5, 0, 1'b0, 1, 3, 32'd0,  40, 3};

        #12;
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_dbg_raddr", dbg_raddr, 0);
        chk("rst_busy_done_pass", {busy, done, pass}, 0);
        chk("rst_results", {mismatch_cnt, fail_idx, fail_val, run_cycles}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cfg_prog_we = 1'b1; cfg_prog_addr = PAW'(i); cfg_prog_data = bufm[i];
        end
        @(negedge clk);
        cfg_prog_we = 1'b0;

        for (int v = 0; v < 7; v++) begin
            load_tables(vt[v].e2, vt[v].e3, vt[v].e0);
            kick(vt[v].len, vt[v].cnt);
            wait_done(vt[v].halt_at, 0, we_cnt, rc, addr_err);
            data_err = 0;
            for (int i = 0; i < we_cnt && i < 16; i++)
                if (cap[i] !== bufm[i]) data_err++;
            chk($sformatf("v%0d_we_cycles", v), we_cnt, vt[v].we);
            chk($sformatf("v%0d_addr_order", v), addr_err, 0);
            chk($sformatf("v%0d_wdata", v), data_err, 0);
            chk($sformatf("v%0d_run_obs", v), rc, vt[v].run);
            chk($sformatf("v%0d_run_cycles", v), run_cycles, vt[v].run);
            chk($sformatf("v%0d_pass", v), pass, vt[v].pass);
            chk($sformatf("v%0d_mismatch", v), mismatch_cnt, vt[v].mis);
            chk($sformatf("v%0d_fail_idx", v), fail_idx, vt[v].fidx);
            chk($sformatf("v%0d_fail_val", v), fail_val, vt[v].fval);
            chk($sformatf("v%0d_idle_flags", v), {busy, core_rst_n, imem_we}, 0);
        end

        // Reset while DONE with a failure recorded clears the results.
        #2 rst_n = 1'b0;
        #1;
        chk("rstdone_done", done, 0);
        chk("rstdone_mis", mismatch_cnt, 0);
        chk("rstdone_fidx", fail_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of LOAD, right after word 1 has been presented.
        kick(5'd3, 4'd3);
        @(negedge clk);
        chk("midload_word1_we", imem_we, 1);
        chk("midload_word1_addr", imem_addr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midload_core_rst_n", core_rst_n, 0);
        chk("midload_imem_we", imem_we, 0);
        chk("midload_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        kick(5'd3, 4'd3);
        wait_done(0, 0, we_cnt, rc, addr_err);
        chk("reload_we_cycles", we_cnt, 3);
        chk("reload_addr_order", addr_err, 0);
        chk("reload_pass", pass, 1);

        // Start and a buffer write during RUN are both ignored.
        kick(5'd3, 4'd3);
        wait_done(0, 3, we_cnt, rc, addr_err);
        chk("poke_run_cycles", run_cycles, 40);
        chk("poke_run_obs", rc, 40);
        chk("poke_pass", pass, 1);
        kick(5'd3, 4'd3);
        wait_done(0, 0, we_cnt, rc, addr_err);
        chk("poke_word0_kept", cap[0], 32'h00a00093);
        chk("poke_rerun_pass", pass, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
